// File: rtl/tone_pkg.sv
// tone_pkg: shared types, note-code constants and the equal-tempered
// pitch function used to build the sequencer's half-period ROM.
//   state_e      : sequencer FSM states
//   NOTE_REST    : code 0, silence
//   NOTE_C4      : code of middle C; codes step one semitone each
//   half_period(): CLK_HZ / (2 * f) in clock cycles, A4 = 440 Hz
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  localparam int NOTE_REST     = 0;
  localparam int NOTE_C4       = 25;
  localparam int SEMIS_PER_OCT = 12;

  // Octave-4 frequencies in millihertz; other octaves are reached by shifting.
  function automatic longint oct4_mhz(input int semi);
    case (semi)
      0:       return 64'sd261626;
      1:       return 64'sd277183;
      2:       return 64'sd293665;
      3:       return 64'sd311127;
      4:       return 64'sd329628;
      5:       return 64'sd349228;
      6:       return 64'sd369994;
      7:       return 64'sd391995;
      8:       return 64'sd415305;
      9:       return 64'sd440000;
      10:      return 64'sd466164;
      11:      return 64'sd493883;
      default: return 64'sd0;
    endcase
  endfunction

  function automatic longint half_period(input int code, input longint clk_hz);
    int     rel;
    int     oct;
    int     semi;
    longint f;
    if (code == NOTE_REST) return 64'sd0;
    rel  = code - NOTE_C4;
    // floor division so codes below C4 land in lower octaves
    oct  = (rel >= 0) ? rel / SEMIS_PER_OCT
                      : -((SEMIS_PER_OCT - 1 - rel) / SEMIS_PER_OCT);
    semi = rel - oct * SEMIS_PER_OCT;
    f    = oct4_mhz(semi);
    if (oct >= 0)
      return (clk_hz * 64'sd1000) / (64'sd2 * (f << oct));
    else
      return ((clk_hz * 64'sd1000) << (-oct)) / (64'sd2 * f);
  endfunction

endpackage

// File: rtl/tone_pitch_lut.sv
// tone_pitch_lut: combinational note-code -> half-period ROM.
//   code_i : note code (0 = rest, yields 0)
//   half_o : half-period in sys_clk cycles
// OVR_EN replaces the computed table with OVR_TABLE (entry n at bits
// [n*HALF_W +: HALF_W]), used where the clock is too slow for real pitches.
module tone_pitch_lut import tone_pkg::*; #(
  parameter int                              CLK_HZ    = 100_000_000,
  parameter int                              NOTE_W    = 6,
  parameter int                              HALF_W    = 20,
  parameter bit                              OVR_EN    = 1'b0,
  parameter logic [(2**NOTE_W)*HALF_W-1:0]   OVR_TABLE = '0
) (
  input  logic [NOTE_W-1:0] code_i,
  output logic [HALF_W-1:0] half_o
);

  localparam int NUM = 2 ** NOTE_W;

  logic [HALF_W-1:0] rom [NUM];

  for (genvar g = 0; g < NUM; g++) begin : g_rom
    localparam longint HP = OVR_EN ? longint'(OVR_TABLE[g*HALF_W +: HALF_W])
                                   : half_period(g, longint'(CLK_HZ));
    if (HP > ((64'sd1 <<< HALF_W) - 64'sd1)) begin : g_range
      $error("tone_pitch_lut: half-period of code %0d does not fit HALF_W", g);
    end
    assign rom[g] = HP[HALF_W-1:0];
  end

  assign half_o = rom[code_i];

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays {note, dur} entries from a synchronous score ROM
// as a square wave on speaker/buzzer.
//   sys_clk, rst        : clock, async active-high reset
//   start, stop         : one-cycle play / abort requests (stop wins)
//   loop_en             : wrap to entry 0 at end of score
//   score_len           : entry count, latched at start
//   score_addr/data     : ROM port, data valid one cycle after addr
//   speaker, buzzer     : square wave (buzzer is a copy)
//   busy, done, note_cur: status
//
// state | meaning
// IDLE  | waiting for start
// FETCH | score_addr presented, ROM read in flight
// LOAD  | capture note, duration and half-period
// PLAY  | tone and duration counters running
module tone_sequencer import tone_pkg::*; #(
  parameter int                              CLK_HZ        = 100_000_000,
  parameter int                              BEAT_HZ       = 8,
  parameter int                              ADDR_W        = 8,
  parameter int                              NOTE_W        = 6,
  parameter int                              DUR_W         = 4,
  parameter int                              HALF_W        = 20,
  parameter bit                              LUT_OVR_EN    = 1'b0,
  parameter logic [(2**NOTE_W)*HALF_W-1:0]   LUT_OVR_TABLE = '0
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       score_len,
  output logic [ADDR_W-1:0]       score_addr,
  input  logic [NOTE_W+DUR_W-1:0] score_data,
  output logic                    speaker,
  output logic                    buzzer,
  output logic                    busy,
  output logic                    done,
  output logic [NOTE_W-1:0]       note_cur
);

  localparam int PRESC_N = CLK_HZ / BEAT_HZ;
  localparam int PRESC_W = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_N - 1);

  if (PRESC_N < 1) begin : g_presc_chk
    $error("tone_sequencer: CLK_HZ/BEAT_HZ must be at least 1");
  end

  state_e              state_q,  state_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [ADDR_W-1:0]   len_q,    len_d;
  logic [DUR_W-1:0]    dur_q,    dur_d;
  logic [HALF_W-1:0]   half_q,   half_d;
  logic [PRESC_W-1:0]  presc_q,  presc_d;
  logic [HALF_W-1:0]   tone_q,   tone_d;
  logic                spk_q,    spk_d;
  logic [NOTE_W-1:0]   note_q,   note_d;
  logic                done_q,   done_d;
  logic                busy_q,   busy_d;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic [HALF_W-1:0]   lut_half;
  logic                wrap;
  logic                note_end;
  logic                last;
  logic                silent;

  assign rom_note = score_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = score_data[DUR_W-1:0];

  tone_pitch_lut #(
    .CLK_HZ    (CLK_HZ),
    .NOTE_W    (NOTE_W),
    .HALF_W    (HALF_W),
    .OVR_EN    (LUT_OVR_EN),
    .OVR_TABLE (LUT_OVR_TABLE)
  ) u_lut (
    .code_i (rom_note),
    .half_o (lut_half)
  );

  assign wrap     = (presc_q == PRESC_MAX);
  assign note_end = (state_q == ST_PLAY) && wrap && (dur_q == '0);
  assign last     = (addr_q == len_q - 1'b1);
  assign silent   = (note_q == '0) || (half_q == '0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      dur_q   <= '0;
      half_q  <= '0;
      presc_q <= '0;
      tone_q  <= '0;
      spk_q   <= 1'b0;
      note_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      presc_q <= presc_d;
      tone_q  <= tone_d;
      spk_q   <= spk_d;
      note_q  <= note_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && (score_len != '0)) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_PLAY;
        ST_PLAY:  if (note_end) state_d = (!last || loop_en) ? ST_FETCH : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    dur_d   = dur_q;
    half_d  = half_q;
    presc_d = presc_q;
    tone_d  = tone_q;
    spk_d   = spk_q;
    note_d  = note_q;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    if (stop) begin
      addr_d  = '0;
      dur_d   = '0;
      half_d  = '0;
      presc_d = '0;
      tone_d  = '0;
      spk_d   = 1'b0;
      note_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (score_len != '0) begin
              len_d  = score_len;
              addr_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          note_d  = rom_note;
          dur_d   = rom_dur;
          half_d  = lut_half;
          presc_d = '0;
          tone_d  = '0;
          spk_d   = 1'b0;
        end
        ST_PLAY: begin
          if (wrap) begin
            presc_d = '0;
            if (dur_q != '0) dur_d = dur_q - 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (silent) begin
            spk_d  = 1'b0;
            tone_d = '0;
          end else if (tone_q == half_q - 1'b1) begin
            spk_d  = ~spk_q;
            tone_d = '0;
          end else begin
            tone_d = tone_q + 1'b1;
          end
          // speaker must sit low across the FETCH/LOAD gap
          if (note_end) begin
            spk_d  = 1'b0;
            tone_d = '0;
            if (!last) begin
              addr_d = addr_q + 1'b1;
            end else if (loop_en) begin
              addr_d = '0;
            end else begin
              addr_d = '0;
              note_d = '0;
              done_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign score_addr = addr_q;
  assign speaker    = spk_q;
  assign buzzer     = spk_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign note_cur   = note_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 4;
  localparam int HALF_W = 20;
  localparam int ADDR_W = 8;
  localparam int NOTE_A = 10;
  localparam logic [(2**NOTE_W)*HALF_W-1:0] OVR = 1280'(3) << (NOTE_A * HALF_W);

  localparam int K_BUSY = 0;
  localparam int K_DONE = 1;
  localparam int K_ADDR = 2;
  localparam int K_SPK  = 3;
  localparam int K_NOTE = 4;
  localparam int K_BUZ  = 5;

  logic                    sys_clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    stop;
  logic                    loop_en;
  logic [ADDR_W-1:0]       score_len;
  logic [ADDR_W-1:0]       score_addr;
  logic [NOTE_W+DUR_W-1:0] score_data = '0;
  logic                    speaker;
  logic                    buzzer;
  logic                    busy;
  logic                    done;
  logic [NOTE_W-1:0]       note_cur;

  logic [NOTE_W+DUR_W-1:0] rom [256];

  typedef struct { int cyc; int kind; int val; } exp_t;
  exp_t q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  tone_sequencer #(
    .CLK_HZ        (1000),
    .BEAT_HZ       (100),
    .ADDR_W        (ADDR_W),
    .NOTE_W        (NOTE_W),
    .DUR_W         (DUR_W),
    .HALF_W        (HALF_W),
    .LUT_OVR_EN    (1'b1),
    .LUT_OVR_TABLE (OVR)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .score_len  (score_len),
    .score_addr (score_addr),
    .score_data (score_data),
    .speaker    (speaker),
    .buzzer     (buzzer),
    .busy       (busy),
    .done       (done),
    .note_cur   (note_cur)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) score_data <= rom[score_addr];
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic int sample(input int k);
    case (k)
      K_BUSY:  return int'(busy);
      K_DONE:  return int'(done);
      K_ADDR:  return int'(score_addr);
      K_SPK:   return int'(speaker);
      K_NOTE:  return int'(note_cur);
      K_BUZ:   return int'(buzzer);
      default: return -1;
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_BUSY:  return "busy";
      K_DONE:  return "done";
      K_ADDR:  return "score_addr";
      K_SPK:   return "speaker";
      K_NOTE:  return "note_cur";
      K_BUZ:   return "buzzer";
      default: return "unknown";
    endcase
  endfunction

  // monitor: pops every expectation due this cycle and compares
  always @(negedge sys_clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        int act;
        act = sample(q[i].kind);
        checks++;
        if (q[i].cyc < cyc || act != q[i].val) begin
          errors++;
          $display("FAIL %s cycle %0d: got %0d want %0d (seen at %0d)",
                   kname(q[i].kind), q[i].cyc, act, q[i].val, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic exp_at(input int c, input int k, input int v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  task automatic exp_rng(input int c0, input int c1, input int k, input int v);
    for (int c = c0; c <= c1; c++) exp_at(c, k, v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: pending %0d want 0", q.size());
      q.delete();
    end
    step(2);
  endtask

  task automatic do_start(input int len, output int t);
    score_len = ADDR_W'(len);
    start     = 1'b1;
    t         = cyc;
    step();
    start     = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    int t2;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = {6'(NOTE_A), 4'd1};
    rom[1] = {6'd0, 4'd0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; score_len = '0;
    step(3);

    // reset state
    exp_at(cyc, K_BUSY, 0); exp_at(cyc, K_SPK, 0); exp_at(cyc, K_ADDR, 0);
    exp_at(cyc + 1, K_DONE, 0); exp_at(cyc + 1, K_NOTE, 0); exp_at(cyc + 1, K_BUZ, 0);
    rst = 1'b0;
    drain();

    // basic playback and tone period (half = 3)
    exp_at(cyc, K_BUSY, 0);
    do_start(2, t);
    exp_rng(t + 1, t + 22, K_ADDR, 0);
    exp_rng(t + 1, t + 34, K_BUSY, 1);
    exp_rng(t + 1, t + 34, K_DONE, 0);
    exp_rng(t + 1, t + 2, K_SPK, 0);
    exp_rng(t + 3, t + 22, K_NOTE, NOTE_A);
    for (int k = 0; k < 20; k++) begin
      exp_at(t + 3 + k, K_SPK, (k / 3) % 2);
      exp_at(t + 3 + k, K_BUZ, (k / 3) % 2);
    end
    exp_rng(t + 23, t + 34, K_ADDR, 1);
    exp_rng(t + 23, t + 35, K_SPK, 0);
    exp_rng(t + 25, t + 34, K_NOTE, 0);
    exp_at(t + 35, K_DONE, 1);
    exp_at(t + 35, K_BUSY, 0);
    exp_at(t + 35, K_NOTE, 0);
    exp_at(t + 36, K_DONE, 0);
    drain();

    // loop mode, loop_en dropped mid-play
    loop_en = 1'b1;
    do_start(2, t);
    exp_at(t + 35, K_ADDR, 0);
    exp_at(t + 35, K_BUSY, 1);
    exp_rng(t + 34, t + 68, K_DONE, 0);
    exp_at(t + 57, K_ADDR, 1);
    exp_at(t + 68, K_BUSY, 1);
    exp_at(t + 69, K_DONE, 1);
    exp_at(t + 69, K_BUSY, 0);
    step(39);
    loop_en = 1'b0;
    drain();

    // stop mid-note
    do_start(2, t);
    exp_at(t + 8, K_SPK, 1);
    exp_at(t + 8, K_BUSY, 1);
    exp_at(t + 9, K_BUSY, 0);
    exp_at(t + 9, K_SPK, 0);
    exp_at(t + 9, K_NOTE, 0);
    exp_at(t + 9, K_ADDR, 0);
    exp_rng(t + 9, t + 11, K_DONE, 0);
    step(7);
    stop = 1'b1;
    step();
    stop = 1'b0;
    drain();

    // stop and start together stay idle
    t = cyc;
    exp_rng(t + 1, t + 3, K_BUSY, 0);
    exp_rng(t + 1, t + 3, K_DONE, 0);
    score_len = 8'd2; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    drain();

    // start while busy is ignored (including its score_len)
    do_start(2, t);
    exp_at(t + 12, K_BUSY, 1);
    exp_at(t + 12, K_SPK, 1);
    exp_at(t + 12, K_ADDR, 0);
    exp_at(t + 23, K_BUSY, 1);
    exp_at(t + 23, K_ADDR, 1);
    exp_at(t + 35, K_DONE, 1);
    step(9);
    score_len = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    drain();

    // zero-length score
    exp_at(cyc, K_BUSY, 0);
    do_start(0, t);
    exp_at(t + 1, K_BUSY, 0);
    exp_at(t + 1, K_DONE, 1);
    exp_at(t + 2, K_DONE, 0);
    exp_at(t + 2, K_BUSY, 0);
    drain();

    // asynchronous reset mid-PLAY, then a fresh start
    do_start(2, t);
    step(7);
    exp_at(t + 8, K_BUSY, 0);
    exp_at(t + 8, K_SPK, 0);
    exp_at(t + 8, K_BUZ, 0);
    exp_at(t + 8, K_NOTE, 0);
    exp_at(t + 8, K_ADDR, 0);
    exp_at(t + 8, K_DONE, 0);
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_rng(t + 10, t + 14, K_BUSY, 0);
    drain();
    do_start(2, t2);
    exp_at(t2 + 1, K_BUSY, 1);
    exp_at(t2 + 1, K_ADDR, 0);
    exp_at(t2 + 3, K_NOTE, NOTE_A);
    exp_at(t2 + 35, K_DONE, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
